dcache_direct: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the CPU data port and the line-granular port 2 of the shared memory. It has 8 lines of 4 × 16-bit words. Hits complete in the request cycle. Misses stall the CPU while the cache optionally writes back the dirty victim line and then fills the new line with one 64-bit memory transfer each.

---
 rtl/dcache_direct.sv | 178 +++++++++++++++++
 tb/tb_dcache_direct.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped, write-back, write-allocate data cache.
//
// Eight lines of four 16-bit words. Hits finish in the request cycle. A miss
// stalls the CPU. If the victim line is dirty it is written back first. The
// new line is then filled with one 64-bit memory transfer.
//
// Ports
//   clk, reset_n           clock, synchronous active-low reset
//   cpu_read, cpu_write    load / store request (write wins when both set)
//   cpu_addr, cpu_wdata    word address and store data
//   cpu_rdata              load data, valid when cpu_read && !cpu_stall
//   cpu_stall              access not complete; CPU holds its request
//   mem_read, mem_write    line transfer requests to memory
//   mem_addr, mem_wdata    line address ([1:0]=0) and write-back line
//   mem_rdata, mem_busy    fill line and memory busy indication
//   Line packing: word 0 in [63:48], word 3 in [15:0].
//
// Optional feature macro DCACHE_STATS_EN adds hit_count / miss_count outputs.
// A miss is counted at IDLE->WB/FILL. A hit is counted for an access that hit
// without missing first. The replay after a fill is not counted as a hit.

module dcache_direct #(
  parameter int WORD_SIZE  = 16,
  parameter int LINES      = 8,
  parameter int LINE_WORDS = 4,
  parameter int TAG_BITS   = 11
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              cpu_read,
  input  logic                              cpu_write,
  input  logic [WORD_SIZE-1:0]              cpu_addr,
  input  logic [WORD_SIZE-1:0]              cpu_wdata,
  output logic [WORD_SIZE-1:0]              cpu_rdata,
  output logic                              cpu_stall,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [WORD_SIZE-1:0]              mem_addr,
  output logic [WORD_SIZE*LINE_WORDS-1:0]   mem_wdata,
  input  logic [WORD_SIZE*LINE_WORDS-1:0]   mem_rdata,
  input  logic                              mem_busy
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]                       hit_count,
  output logic [15:0]                       miss_count
`endif
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int LINE_W = WORD_SIZE * LINE_WORDS;
  localparam int SEL_W  = $clog2(LINE_W);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;

  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q, dirty_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [LINE_W-1:0]     data_q [LINES];
  logic                  busy_seen_q;
  // gap_q holds the fill request low for one cycle after a write-back.
  logic                  gap_q;
  // replay_q marks the cycle right after a fill. That cycle re-evaluates the held access.
  logic                  replay_q;

  logic [IDX_W-1:0]      idx;
  logic [OFF_W-1:0]      off;
  logic [TAG_BITS-1:0]   atag;
  logic [SEL_W-1:0]      wsel;
  logic                  access, hit, wr_hit;
  logic                  xfer_done, wb_done, fill_done;

  assign idx    = cpu_addr[OFF_W +: IDX_W];
  assign off    = cpu_addr[OFF_W-1:0];
  assign atag   = cpu_addr[WORD_SIZE-1 -: TAG_BITS];
  // Word 0 occupies the most significant slice of the line.
  assign wsel   = SEL_W'((LINE_WORDS - 1 - int'(off)) * WORD_SIZE);
  assign access = cpu_read || cpu_write;
  assign hit    = valid_q[idx] && (tag_q[idx] == atag);
  assign wr_hit = (state_q == S_IDLE) && cpu_write && hit;

  always_comb begin
    state_d   = state_q;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    xfer_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (hit) begin
            if (cpu_read) cpu_rdata = data_q[idx][wsel +: WORD_SIZE];
          end else begin
            cpu_stall = 1'b1;
            state_d   = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_FILL;
          end
        end
      end
      S_WB: begin
        cpu_stall = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {tag_q[idx], idx, {OFF_W{1'b0}}};
        mem_wdata = data_q[idx];
        xfer_done = busy_seen_q && !mem_busy;
        if (xfer_done) state_d = S_FILL;
      end
      S_FILL: begin
        cpu_stall = 1'b1;
        if (!gap_q) begin
          mem_read  = 1'b1;
          mem_addr  = {cpu_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
          xfer_done = busy_seen_q && !mem_busy;
          if (xfer_done) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wb_done   = (state_q == S_WB)   && xfer_done;
  assign fill_done = (state_q == S_FILL) && xfer_done;

  // Control state: reset applies here only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      busy_seen_q <= 1'b0;
      gap_q       <= 1'b0;
      replay_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= wb_done;
      replay_q <= fill_done;
      if (xfer_done)
        busy_seen_q <= 1'b0;
      else if ((mem_read || mem_write) && mem_busy)
        busy_seen_q <= 1'b1;
      if (wr_hit)  dirty_q[idx] <= 1'b1;
      if (wb_done) dirty_q[idx] <= 1'b0;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Line data and tags. These are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_hit) data_q[idx][wsel +: WORD_SIZE] <= cpu_wdata;
    if (fill_done) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= atag;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_IDLE && access) begin
      if (!hit)          miss_cnt_q <= miss_cnt_q + 16'd1;
      else if (!replay_q) hit_cnt_q <= hit_cnt_q + 16'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Testbench for dcache_direct. It runs directed steps, then random accesses.
// The results are compared against a behavioural cache model and a memory
// responder. The memory accepts a request, stays busy for 6 cycles, and then
// completes the transfer.
// With DCACHE_STATS_EN defined, it also checks the hit/miss counters.

module tb_dcache_direct;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_stall, mem_read, mem_write;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_busy = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  dcache_direct dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Backing memory seen by the responder, and the model's view of memory.
  logic [15:0] phys_mem [65536];
  logic [15:0] ref_mem  [65536];

  // Reference cache model.
  bit          mv [8];
  bit          md [8];
  logic [10:0] mt [8];
  logic [15:0] mdat [8][4];

  int errors = 0;
  int checks = 0;

  // Results of the last access.
  int          r_stalls, r_nwb, r_nfill;
  logic [15:0] r_wbaddr, r_filladdr, r_rdata;
  logic [63:0] r_wbdata;
  bit          r_both, r_timeout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pack_line(input logic [2:0] ix);
    return {mdat[ix][0], mdat[ix][1], mdat[ix][2], mdat[ix][3]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
  endtask

  // Memory responder. It samples requests mid-cycle, drives busy for cycles
  // 2..7 of a request, and completes in cycle 8.
  initial begin
    int          phase;
    bit          served, lat_wr;
    logic [15:0] la;
    logic [63:0] lwd;
    phase = 0; served = 1'b0; lat_wr = 1'b0; la = '0; lwd = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        phase = 0; mem_busy = 1'b0; served = 1'b0;
      end else if (phase != 0) begin
        phase++;
        if (phase == 8) begin
          mem_busy = 1'b0; served = 1'b1; phase = 0;
          if (lat_wr) begin
            for (int k = 0; k < 4; k++) phys_mem[la + 16'(k)] = lwd[63 - 16*k -: 16];
          end else begin
            mem_rdata = {phys_mem[la], phys_mem[la + 16'd1], phys_mem[la + 16'd2], phys_mem[la + 16'd3]};
          end
        end else begin
          mem_busy = 1'b1;
        end
      end else if ((mem_read || mem_write) && !served) begin
        phase = 1; la = mem_addr; lat_wr = mem_write; lwd = mem_wdata;
      end else if (!(mem_read || mem_write)) begin
        served = 1'b0;
      end
    end
  end

  // Drive one CPU access and observe it until it completes. Entered at #1 after a posedge.
  task automatic access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] wd);
    bit pr, pw, fin;
    pr = 0; pw = 0; fin = 0;
    r_stalls = 0; r_nwb = 0; r_nfill = 0; r_both = 0;
    r_wbaddr = '0; r_wbdata = '0; r_filladdr = '0; r_rdata = '0;
    cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      if (mem_write && !pw) begin r_nwb++; r_wbaddr = mem_addr; r_wbdata = mem_wdata; end
      if (mem_read && !pr)  begin r_nfill++; r_filladdr = mem_addr; end
      if (mem_read && mem_write) r_both = 1'b1;
      pw = mem_write; pr = mem_read;
      if (!cpu_stall) begin r_rdata = cpu_rdata; fin = 1; end
      else r_stalls++;
      @(posedge clk); #1;
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
    r_timeout = !fin;
  endtask

  // Predict the outcome with the model, run the access, and compare.
  task automatic step(input string nm, input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] wd);
    logic [2:0]  ix;
    logic [1:0]  of;
    logic [10:0] tg;
    bit          h, ewb;
    int          estall;
    logic [15:0] ewbaddr, efill, erd;
    logic [63:0] ewbdata;
    ix = a[4:2]; of = a[1:0]; tg = a[15:5];
    h   = mv[ix] && (mt[ix] == tg);
    ewb = !h && mv[ix] && md[ix];
    estall = h ? 0 : (ewb ? 18 : 9);
    ewbaddr = '0; ewbdata = '0; efill = '0; erd = '0;
    if (ewb) begin
      ewbaddr = {mt[ix], ix, 2'b00};
      ewbdata = pack_line(ix);
      for (int k = 0; k < 4; k++) ref_mem[ewbaddr + 16'(k)] = mdat[ix][k];
    end
    if (!h) begin
      efill = {a[15:2], 2'b00};
      for (int k = 0; k < 4; k++) mdat[ix][k] = ref_mem[efill + 16'(k)];
      mv[ix] = 1'b1; mt[ix] = tg; md[ix] = 1'b0;
    end
    if (wr) begin
      mdat[ix][of] = wd; md[ix] = 1'b1;
    end else begin
      erd = mdat[ix][of];
    end
    access(rd, wr, a, wd);
    check({nm, ".timeout"}, 64'(r_timeout), 64'd0);
    check({nm, ".stalls"},  64'(r_stalls), 64'(estall));
    check({nm, ".n_wb"},    64'(r_nwb), ewb ? 64'd1 : 64'd0);
    check({nm, ".n_fill"},  64'(r_nfill), h ? 64'd0 : 64'd1);
    check({nm, ".rw_both"}, 64'(r_both), 64'd0);
    if (ewb) begin
      check({nm, ".wb_addr"}, 64'(r_wbaddr), 64'(ewbaddr));
      check({nm, ".wb_data"}, r_wbdata, ewbdata);
    end
    if (!h) check({nm, ".fill_addr"}, 64'(r_filladdr), 64'(efill));
    if (rd && !wr) check({nm, ".rdata"}, 64'(r_rdata), 64'(erd));
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      phys_mem[i] = w;
      ref_mem[i]  = w;
    end
    phys_mem[0] = 16'h9023; phys_mem[1] = 16'h0001; phys_mem[2] = 16'hFFFF; phys_mem[3] = 16'h0000;
    ref_mem[0]  = 16'h9023; ref_mem[1]  = 16'h0001; ref_mem[2]  = 16'hFFFF; ref_mem[3]  = 16'h0000;
    model_reset();

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.cpu_stall", 64'(cpu_stall), 64'd0);
    check("rst.mem_read",  64'(mem_read),  64'd0);
    check("rst.mem_write", 64'(mem_write), 64'd0);
    check("rst.mem_addr",  64'(mem_addr),  64'd0);
    check("rst.mem_wdata", mem_wdata,      64'd0);
    check("rst.cpu_rdata", 64'(cpu_rdata), 64'd0);
`ifdef DCACHE_STATS_EN
    check("rst.hit_count",  64'(hit_count),  64'd0);
    check("rst.miss_count", 64'(miss_count), 64'd0);
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Cold read, then a hit in the same line
    step("cold_rd0", 1, 0, 16'h0000, 16'h0);
    check("cold_rd0.rdata_lit",  64'(r_rdata), 64'h9023);
    check("cold_rd0.stall_lit",  64'(r_stalls), 64'd9);
    check("cold_rd0.fill_lit",   64'(r_filladdr), 64'h0000);
    step("hit_rd1", 1, 0, 16'h0001, 16'h0);
    check("hit_rd1.rdata_lit",   64'(r_rdata), 64'h0001);
    check("hit_rd1.stall_lit",   64'(r_stalls), 64'd0);

    // Write hit, then a conflicting read that forces a write-back
    step("wr_hit2", 0, 1, 16'h0002, 16'hABCD);
    check("wr_hit2.stall_lit",   64'(r_stalls), 64'd0);
    step("dirty_rd22", 1, 0, 16'h0022, 16'h0);
    check("dirty_rd22.nwb_lit",   64'(r_nwb), 64'd1);
    check("dirty_rd22.wbaddr_lit", 64'(r_wbaddr), 64'h0000);
    check("dirty_rd22.wbdata_lit", r_wbdata, 64'h9023_0001_ABCD_0000);
    check("dirty_rd22.fill_lit",  64'(r_filladdr), 64'h0020);
    check("dirty_rd22.rdata_lit", 64'(r_rdata), 64'(ref_mem[16'h22]));
    check("dirty_rd22.wb_mem",    64'(phys_mem[16'h2]), 64'hABCD);

    // Clean victim: a fill with no write-back
    step("evict_rd40", 1, 0, 16'h0040, 16'h0);
    step("clean_rd20", 1, 0, 16'h0020, 16'h0);
    check("clean_rd20.nwb_lit",   64'(r_nwb), 64'd0);
    check("clean_rd20.nfill_lit", 64'(r_nfill), 64'd1);

    // Reset in the 3rd FILL cycle aborts the fill
    cpu_read = 1'b1; cpu_addr = 16'h0060;
    repeat (3) begin @(posedge clk); #1; end
    check("abort.in_fill",  64'(mem_read), 64'd1);
    check("abort.fill_adr", 64'(mem_addr), 64'h0060);
    reset_n = 1'b0; cpu_read = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("abort.mem_read",  64'(mem_read),  64'd0);
    check("abort.mem_write", 64'(mem_write), 64'd0);
    check("abort.cpu_stall", 64'(cpu_stall), 64'd0);
    model_reset();
    step("reread60", 1, 0, 16'h0060, 16'h0);
    check("reread60.stall_lit", 64'(r_stalls), 64'd9);
    check("reread60.nfill_lit", 64'(r_nfill), 64'd1);

    // Simultaneous read+write is treated as a write
    step("rw_both5", 1, 1, 16'h0005, 16'h1234);
    step("rd5", 1, 0, 16'h0005, 16'h0);
    check("rd5.rdata_lit", 64'(r_rdata), 64'h1234);

    // Counter sequence from a fresh reset
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    step("st_miss0",  1, 0, 16'h0000, 16'h0);
    step("st_hit1",   1, 0, 16'h0001, 16'h0);
    step("st_hit3",   1, 0, 16'h0003, 16'h0);
    step("st_miss40", 1, 0, 16'h0040, 16'h0);
`ifdef DCACHE_STATS_EN
    check("stats.hit_count",  64'(hit_count),  64'd2);
    check("stats.miss_count", 64'(miss_count), 64'd2);
`endif

    // Random traffic over a few tags per index
    for (int n = 0; n < 150; n++) begin
      logic [15:0] ra, rwd;
      int          op;
      ra  = 16'($urandom_range(0, 127));
      rwd = 16'($urandom);
      op  = int'($urandom_range(0, 3));
      case (op)
        0, 1:    step("rand_rd", 1, 0, ra, rwd);
        2:       step("rand_wr", 0, 1, ra, rwd);
        default: step("rand_rw", 1, 1, ra, rwd);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
